// File: rtl/bias_ctrl_pkg.sv
// Shared types and constants for the bias RAM sequencer/arbiter.
package bias_ctrl_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int OUT_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } bias_state_e;

endpackage

// File: rtl/bias_out_fifo.sv
// Two-entry synchronous FIFO carrying {last, data} beats towards the stream port.
module bias_out_fifo
  import bias_ctrl_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [OUT_BUF_DEPTH];
  logic [W-1:0] mem_d [OUT_BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy; a push into a full buffer is only taken alongside a pop.
  always_comb begin
    pop_ok_s  = pop && (count_q != 2'd0);
    push_ok_s = push && ((count_q != 2'(OUT_BUF_DEPTH)) || pop_ok_s);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bias_ram_ctrl.sv
// Arbitrates the single-port bias RAM between host loads and compute bursts,
// streaming burst data through a 2-entry buffer with full backpressure.
module bias_ram_ctrl
  import bias_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  bias_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count_s;
  logic [DATA_W:0]   fifo_head_s;
  logic [2:0]        occ_s;
  logic [ADDR_W:0]   issued_nxt_s;
  logic              pop_s, issue_s, ld_fire_s;

  assign b_valid      = (fifo_count_s != 2'd0);
  assign b_data       = fifo_head_s[DATA_W-1:0];
  assign b_last       = fifo_head_s[DATA_W] && b_valid;
  assign pop_s        = b_valid && b_ready;
  assign ld_ready     = rst_n && (state_q == IDLE) && !rd_start;
  assign ld_fire_s    = ld_valid && ld_ready;
  assign rd_busy      = (state_q != IDLE);
  assign rd_done      = done_q;
  assign issued_nxt_s = issued_q + LEN_ONE;
  // Buffered plus in-flight beats, compared against what the buffer can hold after this cycle's pop.
  assign occ_s        = {1'b0, fifo_count_s} + {2'b00, inflight_q};
  assign issue_s      = rst_n && (state_q == BURST) && (issued_q != len_q) &&
                        (occ_s < (3'd2 + {2'b00, pop_s}));

  // RAM port mux: a load and a burst read never coincide because loads are only accepted in IDLE.
  always_comb begin
    if (ld_fire_s) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = ld_addr;
      ram_di   = ld_data;
    end else if (issue_s) begin
      ram_en   = 1'b1;
      ram_we   = 1'b0;
      ram_addr = base_q + issued_q[ADDR_W-1:0];
      ram_di   = ld_data;
    end else begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = ld_addr;
      ram_di   = ld_data;
    end
  end

  // FSM and counter next-state: capture the burst, count issued reads, track the in-flight beat.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issue_s ? issued_nxt_s : issued_q;
    inflight_d  = issue_s;
    infl_last_d = issue_s && (issued_nxt_s == len_q);
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          base_d   = rd_base;
          len_d    = rd_len;
          issued_d = '0;
          if (rd_len != '0) begin
            state_d = BURST;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (issue_s && (issued_nxt_s == len_q)) begin
          state_d = DRAIN;
        end else begin
          state_d = BURST;
        end
      end
      DRAIN: begin
        if (pop_s && b_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any burst without a completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  bias_out_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({infl_last_q, ram_dout}),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_bias_ram_ctrl.sv
// Directed bench for bias_ram_ctrl with a behavioural 1-cycle-latency RAM.
module tb_bias_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        rd_start;
  logic [3:0]  rd_base;
  logic [4:0]  rd_len;
  logic        rd_busy, rd_done;
  logic        b_valid, b_ready, b_last;
  logic [31:0] b_data;
  logic        ram_en, ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_di, ram_dout;

  logic [31:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  int first_v, done_c, done_n;

  always #5 clk = ~clk;

  bias_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  // External single-port RAM: synchronous write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    chk_eq("ld_ready", 32'(ld_ready), 32'd1);
    chk_eq("ld_we", 32'(ram_we), 32'd1);
    next_cycle();
    ld_valid = 1'b0;
  endtask

  // Runs one burst; mode 0 keeps b_ready high, mode 1 drives b_ready 1,0,0,...
  task automatic run_burst(input logic [3:0] base, input logic [4:0] len, input int mode);
    logic stall = 1'b0;
    logic [31:0] pd = 32'd0;
    logic pl = 1'b0;
    got_d.delete(); got_l.delete();
    first_v = -1; done_c = -1;
    rd_start = 1'b1; rd_base = base; rd_len = len; b_ready = 1'b1;
    next_cycle();
    rd_start = 1'b0;
    for (int k = 1; k < 80 && done_c < 0; k++) begin
      b_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      @(negedge clk);
      if (stall) begin
        chk_eq("hold_valid", 32'(b_valid), 32'd1);
        chk_eq("hold_data", b_data, pd);
        chk_eq("hold_last", 32'(b_last), 32'(pl));
      end
      if (b_valid && first_v < 0) first_v = k;
      if (b_valid && b_ready) begin
        got_d.push_back(b_data);
        got_l.push_back(b_last);
      end
      stall = b_valid && !b_ready;
      pd = b_data; pl = b_last;
      if (rd_done) done_c = k;
      next_cycle();
    end
    b_ready = 1'b1;
    chk_eq("burst_done_seen", 32'(done_c >= 0), 32'd1);
    @(negedge clk);
    chk_eq("post_done_pulse", 32'(rd_done), 32'd0);
    chk_eq("post_busy", 32'(rd_busy), 32'd0);
    chk_eq("post_valid", 32'(b_valid), 32'd0);
    next_cycle();
  endtask

  task automatic check_beats(input string tag, input logic [3:0] base, input int len,
                             input logic [31:0] val0);
    logic [31:0] exp_mask;
    logic [31:0] got_mask;
    chk_eq({tag, "_count"}, 32'(got_d.size()), 32'(len));
    exp_mask = 32'd1 << (len - 1);
    got_mask = 32'd0;
    for (int i = 0; i < got_l.size() && i < 32; i++) got_mask[i] = got_l[i];
    chk_eq({tag, "_last"}, got_mask, exp_mask);
    for (int i = 0; i < len && i < got_d.size(); i++)
      chk_eq({tag, "_beat"}, got_d[i], val0 + 32'(4'(base + 4'(i))));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_ok, hs_we, hs_addr, nd, nv;
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 32'd0;
    rd_start = 1'b0; rd_base = 4'd0; rd_len = 5'd0; b_ready = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk_eq("rst_valid", 32'(b_valid), 32'd0);
    chk_eq("rst_busy", 32'(rd_busy), 32'd0);
    chk_eq("rst_done", 32'(rd_done), 32'd0);
    chk_eq("rst_ram_en", 32'(ram_en), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Single-word load then len=1 burst
    do_load(4'd3, 32'hDEADBEEF);
    run_burst(4'd3, 5'd1, 0);
    chk_eq("t1_first_valid", 32'(first_v), 32'd3);
    chk_eq("t1_done_cyc", 32'(done_c), 32'd4);
    chk_eq("t1_count", 32'(got_d.size()), 32'd1);
    chk_eq("t1_data", got_d[0], 32'hDEADBEEF);
    chk_eq("t1_last", 32'(got_l[0]), 32'd1);

    // Fill RAM, wrapping burst
    for (int i = 0; i < 16; i++) do_load(4'(i), 32'h100 + 32'(i));
    run_burst(4'd14, 5'd4, 0);
    chk_eq("t2_first_valid", 32'(first_v), 32'd3);
    chk_eq("t2_done_cyc", 32'(done_c), 32'd7);
    check_beats("t2", 4'd14, 4, 32'h100);

    // Full-depth burst under 1,0,0 backpressure
    run_burst(4'd0, 5'd16, 1);
    check_beats("t3", 4'd0, 16, 32'h100);

    // Burst and load collide; second rd_start mid-burst ignored
    rd_start = 1'b1; rd_base = 4'd0; rd_len = 5'd2;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'h0000CAFE;
    @(negedge clk);
    chk_eq("t4_ld_blocked", 32'(ld_ready), 32'd0);
    chk_eq("t4_no_ram", 32'(ram_en), 32'd0);
    next_cycle();
    rd_start = 1'b0;
    got_d.delete(); got_l.delete();
    ld_ok = -1; hs_we = -1; hs_addr = -1; done_c = -1; nd = 0;
    for (int k = 1; k < 9; k++) begin
      rd_start = (k == 2); rd_base = 4'd8; rd_len = 5'd1;
      @(negedge clk);
      if (ld_valid && ld_ready && ld_ok < 0) begin
        ld_ok = k; hs_we = 32'(ram_we); hs_addr = 32'(ram_addr);
      end
      if (b_valid && b_ready) begin got_d.push_back(b_data); got_l.push_back(b_last); end
      if (rd_done) begin done_c = k; nd++; end
      next_cycle();
      if (ld_ok == k) ld_valid = 1'b0;
    end
    rd_start = 1'b0; ld_valid = 1'b0;
    chk_eq("t4_done_cyc", 32'(done_c), 32'd5);
    chk_eq("t4_done_n", 32'(nd), 32'd1);
    chk_eq("t4_ld_cyc", 32'(ld_ok), 32'd5);
    chk_eq("t4_ld_we", 32'(hs_we), 32'd1);
    chk_eq("t4_ld_addr", 32'(hs_addr), 32'd5);
    check_beats("t4", 4'd0, 2, 32'h100);
    run_burst(4'd5, 5'd1, 0);
    chk_eq("t4_new_data", got_d[0], 32'h0000CAFE);

    // Zero-length burst
    rd_start = 1'b1; rd_base = 4'd2; rd_len = 5'd0;
    @(negedge clk);
    chk_eq("t5_ram_en0", 32'(ram_en), 32'd0);
    next_cycle();
    rd_start = 1'b0;
    @(negedge clk);
    chk_eq("t5_done", 32'(rd_done), 32'd1);
    chk_eq("t5_busy", 32'(rd_busy), 32'd0);
    chk_eq("t5_ram_en1", 32'(ram_en), 32'd0);
    chk_eq("t5_valid", 32'(b_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_eq("t5_done_off", 32'(rd_done), 32'd0);
    next_cycle();

    // Reset during beat 5 of an 8-beat burst
    got_d.delete(); got_l.delete();
    rd_start = 1'b1; rd_base = 4'd0; rd_len = 5'd8;
    next_cycle();
    rd_start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (k == 7) rst_n = 1'b0;
      @(negedge clk);
      if (b_valid && b_ready && k < 7) got_d.push_back(b_data);
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("t6_pre_beats", 32'(got_d.size()), 32'd4);
    chk_eq("t6_beat3", got_d[3], 32'h103);
    chk_eq("t6_valid", 32'(b_valid), 32'd0);
    chk_eq("t6_last", 32'(b_last), 32'd0);
    chk_eq("t6_busy", 32'(rd_busy), 32'd0);
    chk_eq("t6_done", 32'(rd_done), 32'd0);
    chk_eq("t6_ram_en", 32'(ram_en), 32'd0);
    chk_eq("t6_ram_we", 32'(ram_we), 32'd0);
    chk_eq("t6_ld_ready", 32'(ld_ready), 32'd1);
    nd = 0; nv = 0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      @(negedge clk);
      if (rd_done) nd++;
      if (b_valid) nv++;
    end
    next_cycle();
    chk_eq("t6_no_done", 32'(nd), 32'd0);
    chk_eq("t6_no_valid", 32'(nv), 32'd0);
    do_load(4'd2, 32'h000055AA);
    run_burst(4'd2, 5'd1, 0);
    chk_eq("t6_after_data", got_d[0], 32'h000055AA);
    chk_eq("t6_after_done", 32'(done_c), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
